// File: rtl/varredura_servo_if.sv
// Sweep sequencer bus: enable, measurement
// handshake, position and status pulses.
interface varredura_servo_if;
  logic       ligar;
  logic       fim_medida;
  logic [2:0] posicao;
  logic       medir;
  logic       amostra;
  logic       erro_timeout;
  logic       fim_varredura;
  logic [2:0] db_estado;

  modport master (
    input  ligar,
    input  fim_medida,
    output posicao,
    output medir,
    output amostra,
    output erro_timeout,
    output fim_varredura,
    output db_estado
  );

  modport slave (
    output ligar,
    output fim_medida,
    input  posicao,
    input  medir,
    input  amostra,
    input  erro_timeout,
    input  fim_varredura,
    input  db_estado
  );
endinterface

// File: rtl/varredura_servo.sv
// Ping-pong servo sweep: settle, trigger a
// measurement, wait for result or timeout, advance.
module varredura_servo #(
  parameter int T_ESPERA  = 25000000,
  parameter int T_TIMEOUT = 2500000
) (
  input logic clock,
  input logic reset,
  varredura_servo_if.master bus
);
  localparam int T_MAX =
    (T_ESPERA > T_TIMEOUT) ? T_ESPERA : T_TIMEOUT;
  localparam int CW =
    (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [CW-1:0] ESP_FIM =
    CW'(T_ESPERA - 1);
  localparam logic [CW-1:0] TOUT_FIM =
    CW'(T_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SETTLE    = 3'd1,
    TRIGGER   = 3'd2,
    WAIT_MEAS = 3'd3,
    ADVANCE   = 3'd4
  } estado_t;

  estado_t       estado;
  logic [CW-1:0] cont;
  logic [2:0]    posicao;
  logic          desce;
  logic          medir;
  logic          amostra;
  logic          erro;
  logic          fim_var;
  logic          extremo;

  // endpoint: top going up or bottom going down
  assign extremo =
    (posicao == 3'd7 && !desce) ||
    (posicao == 3'd0 &&  desce);

  // sequencer with registered pulses and position
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= IDLE;
      cont    <= '0;
      posicao <= 3'd0;
      desce   <= 1'b0;
      medir   <= 1'b0;
      amostra <= 1'b0;
      erro    <= 1'b0;
      fim_var <= 1'b0;
    end else begin
      medir   <= 1'b0;
      amostra <= 1'b0;
      erro    <= 1'b0;
      fim_var <= 1'b0;
      case (estado)
        IDLE: begin
          cont <= '0;
          if (bus.ligar)
            estado <= SETTLE;
        end
        SETTLE: begin
          if (!bus.ligar) begin
            estado <= IDLE;
            cont   <= '0;
          end else if (cont == ESP_FIM) begin
            estado <= TRIGGER;
            cont   <= '0;
            medir  <= 1'b1;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        TRIGGER: begin
          cont   <= '0;
          estado <= bus.ligar ? WAIT_MEAS : IDLE;
        end
        WAIT_MEAS: begin
          if (!bus.ligar) begin
            estado <= IDLE;
            cont   <= '0;
          end else if (bus.fim_medida) begin
            estado  <= ADVANCE;
            cont    <= '0;
            amostra <= 1'b1;
            fim_var <= extremo;
          end else if (cont == TOUT_FIM) begin
            estado  <= ADVANCE;
            cont    <= '0;
            erro    <= 1'b1;
            fim_var <= extremo;
          end else begin
            cont <= cont + 1'b1;
          end
        end
        ADVANCE: begin
          cont   <= '0;
          estado <= bus.ligar ? SETTLE : IDLE;
          if (extremo) begin
            desce   <= ~desce;
            posicao <= desce ? posicao + 3'd1
                             : posicao - 3'd1;
          end else begin
            posicao <= desce ? posicao - 3'd1
                             : posicao + 3'd1;
          end
        end
        default: begin
          estado <= IDLE;
          cont   <= '0;
        end
      endcase
    end
  end

  assign bus.posicao       = posicao;
  assign bus.medir         = medir;
  assign bus.amostra       = amostra;
  assign bus.erro_timeout  = erro;
  assign bus.fim_varredura = fim_var;
  assign bus.db_estado     = estado;
endmodule
